// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and default timing.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_REL_MEM   = 3'd3,
    ST_REL_CORE  = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 1048576;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGE_GAP      = 16;

  localparam logic [3:0] RETRY_MAX = 4'd15;

  // Largest of the four cycle counts; sizes the shared counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// N-flop synchronizer with async clear; output is low until the input has
// been seen high through every stage.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the PLL out of reset, waits for a stable lock, then releases the
// memory/video reset, the core reset and finally ready, in that order.
// Retries the PLL on lock timeout; re-sequences on lock loss or user reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       user_reset,
  output logic       pll_rst,
  output logic       mem_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                     STABLE_CYCLES, STAGE_GAP)) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_s;
  logic             retry_inc;
  logic             pll_rst_d, mem_rst_d, core_rst_d, ready_d;

  lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next state, counter and Moore output decode of the next state.
  // Lock loss outranks user reset, which outranks counter expiry.
  always_comb begin
    state_nxt  = state;
    retry_inc  = 1'b0;
    pll_rst_d  = 1'b0;
    mem_rst_d  = 1'b1;
    core_rst_d = 1'b1;
    ready_d    = 1'b0;

    case (state)
      ST_PLL_RESET: if (cnt == PLL_RST_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) state_nxt = ST_STABILIZE;
        else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_PLL_RESET;
          retry_inc = 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s)                  state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = ST_REL_MEM;
      end
      ST_REL_MEM: begin
        if (!lock_s)                          state_nxt = ST_WAIT_LOCK;
        else if (!user_reset && cnt == GAP_LAST) state_nxt = ST_REL_CORE;
      end
      ST_REL_CORE: begin
        if (!lock_s)              state_nxt = ST_WAIT_LOCK;
        else if (user_reset)      state_nxt = ST_REL_MEM;
        else if (cnt == GAP_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s)         state_nxt = ST_WAIT_LOCK;
        else if (user_reset) state_nxt = ST_REL_MEM;
      end
      default: state_nxt = ST_PLL_RESET;
    endcase

    // Counter restarts on every transition and is pinned while user reset
    // holds the sequence in REL_MEM.
    if (state_nxt != state)                         cnt_nxt = '0;
    else if (state == ST_REL_MEM && user_reset)     cnt_nxt = '0;
    else                                            cnt_nxt = cnt + 1'b1;

    case (state_nxt)
      ST_PLL_RESET: pll_rst_d = 1'b1;
      ST_REL_MEM:   mem_rst_d = 1'b0;
      ST_REL_CORE: begin
        mem_rst_d  = 1'b0;
        core_rst_d = 1'b0;
      end
      ST_RUN: begin
        mem_rst_d  = 1'b0;
        core_rst_d = 1'b0;
        ready_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter, retry counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PLL_RESET;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      mem_rst     <= 1'b1;
      core_rst    <= 1'b1;
      ready       <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pll_rst  <= pll_rst_d;
      mem_rst  <= mem_rst_d;
      core_rst <= core_rst_d;
      ready    <= ready_d;
      if (retry_inc && retry_count != RETRY_MAX) retry_count <= retry_count + 1'b1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened timing.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       user_reset;
  logic       pll_rst, mem_rst, core_rst, ready;
  logic [3:0] retry_count;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_PRST = 3'd0, S_WAIT = 3'd1, S_STAB = 3'd2,
                         S_RMEM = 3'd3, S_RCORE = 3'd4, S_RUN = 3'd5;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(64),
    .STABLE_CYCLES(8), .STAGE_GAP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .user_reset(user_reset),
    .pll_rst(pll_rst), .mem_rst(mem_rst), .core_rst(core_rst), .ready(ready),
    .retry_count(retry_count), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Packed view of the four reset/ready outputs: {pll_rst, mem_rst, core_rst, ready}.
  function automatic logic [31:0] outs();
    return 32'({pll_rst, mem_rst, core_rst, ready});
  endfunction

  task automatic wait_state(input logic [2:0] st, input int max, output int cyc);
    cyc = 0;
    while (state_dbg !== st && cyc < max) begin
      tick(1);
      cyc++;
    end
    check("wait_state_reached", 32'(state_dbg), 32'(st));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; pll_locked = 1'b0; user_reset = 1'b0;

    // Power-up
    tick(3);
    check("rst_state", 32'(state_dbg), 32'(S_PRST));
    check("rst_outs", outs(), 32'b1110);
    check("rst_retry", 32'(retry_count), 0);
    rst_n = 1'b1;
    tick(3);
    check("pu_pllrst_held", outs(), 32'b1110);
    tick(1);
    check("pu_wait_state", 32'(state_dbg), 32'(S_WAIT));
    check("pu_wait_outs", outs(), 32'b0110);
    tick(6);
    pll_locked = 1'b1;
    tick(2);
    check("pu_sync_latency", 32'(state_dbg), 32'(S_WAIT));
    tick(1);
    check("pu_stab_entry", 32'(state_dbg), 32'(S_STAB));
    tick(7);
    check("pu_stab_hold", outs(), 32'b0110);
    tick(1);
    check("pu_relmem", 32'(state_dbg), 32'(S_RMEM));
    check("pu_relmem_outs", outs(), 32'b0010);
    tick(3);
    check("pu_core_held", outs(), 32'b0010);
    tick(1);
    check("pu_relcore_outs", outs(), 32'b0000);
    tick(3);
    check("pu_ready_held", outs(), 32'b0000);
    tick(1);
    check("pu_run", 32'(state_dbg), 32'(S_RUN));
    check("pu_run_outs", outs(), 32'b0001);

    // User reset in RUN for 10 cycles
    user_reset = 1'b1;
    tick(1);
    check("ur_relmem", 32'(state_dbg), 32'(S_RMEM));
    check("ur_outs", outs(), 32'b0010);
    tick(9);
    check("ur_held", 32'(state_dbg), 32'(S_RMEM));
    user_reset = 1'b0;
    tick(3);
    check("ur_core_still", outs(), 32'b0010);
    tick(1);
    check("ur_core_rel", outs(), 32'b0000);
    tick(3);
    check("ur_ready_still", outs(), 32'b0000);
    tick(1);
    check("ur_ready", outs(), 32'b0001);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    check("ll_before", outs(), 32'b0001);
    tick(1);
    check("ll_state", 32'(state_dbg), 32'(S_WAIT));
    check("ll_outs", outs(), 32'b0110);
    pll_locked = 1'b1;
    tick(3);
    check("ll_restab", 32'(state_dbg), 32'(S_STAB));
    wait_state(S_RUN, 40, cyc);
    check("ll_reseq_cycles", 32'(cyc), 16);

    // Glitchy lock
    pll_locked = 1'b0;
    tick(3);
    check("gl_wait", 32'(state_dbg), 32'(S_WAIT));
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    check("gl_stab", 32'(state_dbg), 32'(S_STAB));
    tick(1);
    check("gl_stab2", 32'(state_dbg), 32'(S_STAB));
    tick(1);
    check("gl_back_wait", 32'(state_dbg), 32'(S_WAIT));
    check("gl_resets_held", outs(), 32'b0110);
    tick(1);
    check("gl_restab", 32'(state_dbg), 32'(S_STAB));
    tick(7);
    check("gl_no_early_rel", outs(), 32'b0110);
    tick(1);
    check("gl_relmem", 32'(state_dbg), 32'(S_RMEM));
    check("gl_retry", 32'(retry_count), 0);
    wait_state(S_RUN, 20, cyc);

    // Lock loss and user reset reaching the FSM in the same cycle
    pll_locked = 1'b0;
    tick(2);
    user_reset = 1'b1;
    tick(1);
    check("sim_state", 32'(state_dbg), 32'(S_WAIT));
    check("sim_outs", outs(), 32'b0110);
    user_reset = 1'b0;

    // rst_n asserted mid-REL_CORE
    pll_locked = 1'b1;
    wait_state(S_RCORE, 40, cyc);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state_dbg), 32'(S_PRST));
    check("async_outs", outs(), 32'b1110);
    pll_locked = 1'b0;
    tick(1);
    rst_n = 1'b1;

    // Lock timeout with pll_locked held low
    tick(67);
    check("to_before", 32'(retry_count), 0);
    check("to_before_pll", outs(), 32'b0110);
    tick(1);
    check("to_retry1", 32'(retry_count), 1);
    check("to_repulse", outs(), 32'b1110);
    tick(3);
    check("to_pulse_len", 32'(pll_rst), 1);
    tick(1);
    check("to_pulse_end", 32'(state_dbg), 32'(S_WAIT));
    tick(64);
    check("to_retry2", 32'(retry_count), 2);
    tick(68 * 13);
    check("to_retry15", 32'(retry_count), 15);
    tick(68 * 2);
    check("to_saturate", 32'(retry_count), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
